div_io_ctrl: RTL and testbench

- Byte-serial front/back-end controller for the shared divider core (SRT2 integer / fp32 path).
- Assembles a 32-bit dividend and divisor from push-strobed bytes, starts the core, and waits for completion with a watchdog.
- Handles divide-by-zero without invoking the core.
- Serializes remainder then quotient back out as bytes, framed by a one-cycle pull_out strobe.

---
 rtl/div_io_ctrl_if.sv | 36 +++
 rtl/div_io_ctrl.sv | 115 +++++++++++
 tb/tb_div_io_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_io_ctrl_if.sv
// Byte-stream and divider-core signal bundle for div_io_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface div_io_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             push_in;
  logic [7:0]       data_in_in;
  logic             sign;
  logic             select;
  logic             div_start;
  logic             div_sign;
  logic             div_select;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             pull_out;
  logic [7:0]       data_out_out;
  logic             sign_out;
  logic             busy;
  logic             drop_err;
  logic             timeout_err;

  modport master (
    output push_in, data_in_in, sign, select, div_done, div_quotient, div_remainder,
    input  div_start, div_sign, div_select, div_dividend, div_divisor,
           pull_out, data_out_out, sign_out, busy, drop_err, timeout_err
  );

  modport slave (
    input  push_in, data_in_in, sign, select, div_done, div_quotient, div_remainder,
    output div_start, div_sign, div_select, div_dividend, div_divisor,
           pull_out, data_out_out, sign_out, busy, drop_err, timeout_err
  );
endinterface

// File: rtl/div_io_ctrl.sv
// Byte-serial front/back end for the shared divider core: assembles operands,
// runs the core under a watchdog, and streams remainder then quotient back out.
module div_io_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  div_io_ctrl_if.slave bus
);
  localparam int unsigned NB     = WIDTH / 8;
  localparam int unsigned NBYTES = 2 * NB;
  localparam int unsigned CW     = $clog2(NBYTES + 1);
  localparam int unsigned WW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_COLLECT, S_ZCHK, S_START, S_WAIT, S_ANNOUNCE, S_SEND
  } state_t;

  state_t             state, state_n;
  logic [2*WIDTH-1:0] sr;
  logic [2*WIDTH-1:0] res;
  logic [CW-1:0]      cnt;
  logic [WW-1:0]      wd;
  logic               sign_l, select_l, sign_o, tmo;
  logic [7:0]         dout;
  logic               last_push, div_zero, wd_expire, last_byte;

  always_comb begin
    last_push = (state == S_COLLECT) && bus.push_in && (cnt == CW'(NBYTES - 1));
    div_zero  = (sr[WIDTH-1:0] == '0);
    wd_expire = (wd == WW'(TIMEOUT - 1));
    last_byte = (cnt == CW'(NBYTES - 1));
    state_n   = state;
    case (state)
      S_COLLECT:  if (last_push) state_n = S_ZCHK;
      S_ZCHK:     state_n = div_zero ? S_ANNOUNCE : S_START;
      S_START:    state_n = S_WAIT;
      // done takes priority over an expiring watchdog in the same cycle
      S_WAIT:     if (bus.div_done) state_n = S_ANNOUNCE;
                  else if (wd_expire) state_n = S_COLLECT;
      S_ANNOUNCE: state_n = S_SEND;
      S_SEND:     if (last_byte) state_n = S_COLLECT;
      default:    state_n = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_COLLECT;
      sr       <= '0;
      res      <= '0;
      cnt      <= '0;
      wd       <= '0;
      sign_l   <= 1'b0;
      select_l <= 1'b0;
      sign_o   <= 1'b0;
      tmo      <= 1'b0;
      dout     <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_ANNOUNCE) sign_o <= sign_l;
      case (state)
        S_COLLECT: if (bus.push_in) begin
          sr <= {sr[2*WIDTH-9:0], bus.data_in_in};
          if (last_push) begin
            cnt      <= '0;
            sign_l   <= bus.sign;
            select_l <= bus.select;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ZCHK: if (div_zero) res <= {{WIDTH{1'b1}}, sr[2*WIDTH-1:WIDTH]};
        S_START: begin
          wd  <= '0;
          tmo <= 1'b0;
        end
        S_WAIT: if (bus.div_done) begin
          res <= {bus.div_quotient, bus.div_remainder};
        end else begin
          wd <= wd + 1'b1;
          if (wd_expire) tmo <= 1'b1;
        end
        // res holds {quotient, remainder}; shifting right emits remainder LSB first
        S_ANNOUNCE: begin
          dout <= res[7:0];
          res  <= res >> 8;
          cnt  <= '0;
        end
        S_SEND: if (last_byte) begin
          dout <= '0;
          cnt  <= '0;
        end else begin
          dout <= res[7:0];
          res  <= res >> 8;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.div_start    = (state == S_START);
  assign bus.div_sign     = sign_l;
  assign bus.div_select   = select_l;
  assign bus.div_dividend = sr[2*WIDTH-1:WIDTH];
  assign bus.div_divisor  = sr[WIDTH-1:0];
  assign bus.pull_out     = (state == S_ANNOUNCE);
  assign bus.data_out_out = dout;
  assign bus.sign_out     = sign_o;
  assign bus.busy         = (state != S_COLLECT);
  assign bus.drop_err     = bus.push_in && (state != S_COLLECT);
  assign bus.timeout_err  = tmo;
endmodule

// File: tb/tb_div_io_ctrl.sv
// Scoreboard bench for div_io_ctrl with a behavioural divider-core model.
module tb_div_io_ctrl;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_io_ctrl_if #(.WIDTH(WIDTH)) bus();
  div_io_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct packed {
    logic        sgn;
    logic [63:0] payload;  // {quotient, remainder}
    logic [31:0] lat;
  } frame_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        sel;
  } op_t;

  frame_t      exp_frames[$];
  op_t         exp_ops[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned last_push_cyc = 0;
  int unsigned start_cyc = 0;
  int          frames_seen = 0;
  int          drops_seen = 0;
  int          core_delay = 1;
  frame_t      cur;
  op_t         mon_op;
  int          idx = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Opaque core: true unsigned division for integer unsigned, arbitrary mixing otherwise.
  function automatic logic [63:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input logic sel);
    if (!sgn && !sel) return {a / b, a % b};
    return {a ^ {b[15:0], b[31:16]}, a - b};
  endfunction

  initial begin
    logic [63:0] qr;
    bus.div_done      = 1'b0;
    bus.div_quotient  = $urandom;
    bus.div_remainder = $urandom;
    forever begin
      @(negedge clk);
      if (rst_n && bus.div_start) begin
        qr = core_fn(bus.div_dividend, bus.div_divisor, bus.div_sign, bus.div_select);
        repeat (core_delay) @(posedge clk);
        #1;
        bus.div_done = 1'b1;
        {bus.div_quotient, bus.div_remainder} = qr;
        @(posedge clk);
        #1;
        bus.div_done      = 1'b0;
        bus.div_quotient  = $urandom;
        bus.div_remainder = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      idx = -1;
    end else begin
      if (bus.drop_err) drops_seen++;
      if (bus.div_start) begin
        start_cyc = cyc;
        if (exp_ops.size() == 0) chk("unexpected_div_start", exp_ops.size(), 1);
        else begin
          mon_op = exp_ops.pop_front();
          chk("div_operands", {bus.div_dividend, bus.div_divisor}, {mon_op.a, mon_op.b});
          chk("div_sign_select", {bus.div_sign, bus.div_select}, {mon_op.sgn, mon_op.sel});
        end
      end
      if (idx >= 0) begin
        if (idx < 8) begin
          chk($sformatf("out_byte%0d", idx), bus.data_out_out, cur.payload[8*idx +: 8]);
          idx++;
        end else begin
          chk("out_idle", {bus.data_out_out, bus.busy}, 9'h0);
          idx = -1;
          frames_seen++;
        end
      end else if (bus.pull_out) begin
        if (exp_frames.size() == 0) chk("unexpected_pull_out", exp_frames.size(), 1);
        else begin
          cur = exp_frames.pop_front();
          chk("announce", {bus.data_out_out, bus.sign_out, bus.busy}, {8'h00, cur.sgn, 1'b1});
          chk("latency", cyc - last_push_cyc, cur.lat);
          idx = 0;
        end
      end
    end
  end

  task automatic push_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic sel);
    logic [63:0] w;
    w = {a, b};
    for (int i = 0; i < 8; i++) begin
      bus.push_in    = 1'b1;
      bus.data_in_in = w[63-8*i -: 8];
      bus.sign       = (i == 7) ? sgn : 1'($urandom);
      bus.select     = (i == 7) ? sel : 1'($urandom);
      if (i == 7) last_push_cyc = cyc;
      @(posedge clk);
      #1;
    end
    bus.push_in = 1'b0;
    bus.sign    = 1'($urandom);
    bus.select  = 1'($urandom);
  endtask

  task automatic expect_frame(input logic [31:0] a, input logic [31:0] b,
                              input logic sgn, input logic sel, input int d);
    frame_t f;
    op_t    o;
    f.sgn = sgn;
    if (b == 0) begin
      f.payload = {32'hFFFF_FFFF, a};
      f.lat     = 2;
    end else begin
      f.payload = core_fn(a, b, sgn, sel);
      f.lat     = 32'(d + 3);
      o.a = a; o.b = b; o.sgn = sgn; o.sel = sel;
      exp_ops.push_back(o);
    end
    exp_frames.push_back(f);
  endtask

  task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic sel, input int d, input bit overrun);
    int seen0, drops0, exp_drops;
    bit done;
    core_delay = d;
    expect_frame(a, b, sgn, sel, d);
    seen0 = frames_seen;
    drops0 = drops_seen;
    exp_drops = 0;
    push_frame(a, b, sgn, sel);
    done = 0;
    for (int i = 0; i < 300; i++) begin
      if (frames_seen != seen0) begin
        done = 1;
        break;
      end
      if (overrun && bus.busy && $urandom_range(3) == 0) begin
        bus.push_in    = 1'b1;
        bus.data_in_in = 8'($urandom);
        exp_drops++;
      end
      @(posedge clk);
      #1;
      bus.push_in = 1'b0;
    end
    chk("frame_done", 64'(done), 1);
    chk("drop_count", drops_seen - drops0, exp_drops);
  endtask

  task automatic watchdog_frame();
    op_t o;
    bit  done;
    core_delay = TIMEOUT + 1;  // done arrives one cycle after the abort and must be ignored
    o.a = 32'h0000_1234; o.b = 32'h0000_0005; o.sgn = 1'b0; o.sel = 1'b0;
    exp_ops.push_back(o);
    push_frame(o.a, o.b, o.sgn, o.sel);
    done = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.timeout_err) begin
        done = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("timeout_seen", 64'(done), 1);
    chk("timeout_latency", cyc - start_cyc, TIMEOUT + 1);
    chk("timeout_idle", {bus.busy, bus.pull_out}, 2'b00);
    repeat (6) @(posedge clk);
    #1;
    chk("timeout_sticky", {bus.timeout_err, bus.busy}, 2'b10);
  endtask

  task automatic reset_mid_send();
    bit got;
    core_delay = 7;
    expect_frame(32'hCAFE_F00D, 32'h0000_0123, 1'b1, 1'b1, 7);
    push_frame(32'hCAFE_F00D, 32'h0000_0123, 1'b1, 1'b1);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.pull_out) begin
        got = 1;
        break;
      end
    end
    chk("rst_pull_seen", 64'(got), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctrl_outputs", {bus.div_start, bus.div_sign, bus.div_select, bus.pull_out,
        bus.data_out_out, bus.sign_out, bus.busy, bus.drop_err, bus.timeout_err}, '0);
    chk("rst_operands", {bus.div_dividend, bus.div_divisor}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    bus.push_in    = 1'b0;
    bus.data_in_in = '0;
    bus.sign       = 1'b0;
    bus.select     = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_outputs", {bus.div_start, bus.div_sign, bus.div_select, bus.pull_out,
        bus.data_out_out, bus.sign_out, bus.busy, bus.drop_err, bus.timeout_err}, '0);
    chk("reset_operands", {bus.div_dividend, bus.div_divisor}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(32'd100, 32'd7, 1'b0, 1'b0, 34, 1'b0);
    run_frame(32'h1234_5678, 32'h0, 1'b0, 1'b0, 1, 1'b0);
    run_frame(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 10, 1'b0);
    run_frame($urandom, $urandom | 32'h1, 1'b0, 1'b0, TIMEOUT, 1'b0);
    watchdog_frame();
    run_frame(32'd1000, 32'd3, 1'b0, 1'b1, 5, 1'b0);
    chk("timeout_cleared", bus.timeout_err, 1'b0);
    run_frame(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b0, 20, 1'b1);
    run_frame(32'h0BAD_F00D, 32'h0, 1'b1, 1'b1, 1, 1'b1);
    reset_mid_send();
    run_frame(32'h0000_FFFF, 32'h0000_0010, 1'b0, 1'b0, 3, 1'b0);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = ($urandom_range(3) == 0) ? 32'h0 : ($urandom >> $urandom_range(31));
      run_frame(a, b, 1'($urandom), 1'($urandom), $urandom_range(TIMEOUT, 1),
                1'($urandom));
    end

    chk("queues_drained", 64'(exp_frames.size() + exp_ops.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
